// File: rtl/fetch_pkg.sv
// Shared types and constants for the instruction-fetch stage.
package fetch_pkg;

  typedef enum logic [1:0] {StIdle, StWait, StFault} fetch_state_t;

  localparam logic [1:0] FC_NONE     = 2'b00;
  localparam logic [1:0] FC_MISALIGN = 2'b01;
  localparam logic [1:0] FC_RANGE    = 2'b10;
  localparam logic [1:0] FC_TIMEOUT  = 2'b11;

  localparam logic [31:0] NOP_DEFAULT = 32'h0000_0000;

endpackage

// File: rtl/fetch_buffer.sv
// Tag/data/valid instruction buffer with 1 or 2 entries, hit compare and instr mux.
// A second lookup port checks whether an arbitrary address is already buffered.
module fetch_buffer
  import fetch_pkg::*;
#(
  parameter int unsigned Entries = 1,
  parameter logic [31:0] Nop     = NOP_DEFAULT
) (
  input  logic        clk_i,
  input  logic        rst_ni,
  input  logic [31:0] pc_i,
  input  logic [31:0] la_addr_i,
  input  logic        wr_en_i,
  input  logic        wr_idx_i,
  input  logic [31:0] wr_tag_i,
  input  logic [31:0] wr_data_i,
  output logic        hit_o,
  output logic        hit_idx_o,
  output logic        la_hit_o,
  output logic [31:0] instr_o
);

  logic [31:0]        tag_q  [Entries];
  logic [31:0]        data_q [Entries];
  logic [Entries-1:0] v_q;

  always_ff @(posedge clk_i or negedge rst_ni) begin
    if (!rst_ni) begin
      v_q <= '0;
      for (int i = 0; i < int'(Entries); i++) begin
        tag_q[i]  <= '0;
        data_q[i] <= '0;
      end
    end else if (wr_en_i) begin
      for (int i = 0; i < int'(Entries); i++) begin
        if (int'(wr_idx_i) == i) begin
          tag_q[i]  <= wr_tag_i;
          data_q[i] <= wr_data_i;
          v_q[i]    <= 1'b1;
        end
      end
    end
  end

  always_comb begin
    hit_o     = 1'b0;
    hit_idx_o = 1'b0;
    la_hit_o  = 1'b0;
    instr_o   = Nop;
    for (int i = 0; i < int'(Entries); i++) begin
      if (v_q[i] && tag_q[i] == pc_i && !hit_o) begin
        hit_o     = 1'b1;
        hit_idx_o = 1'(i);
        instr_o   = data_q[i];
      end
      if (v_q[i] && tag_q[i] == la_addr_i) la_hit_o = 1'b1;
    end
  end

endmodule

// File: rtl/fetch_unit.sv
// Instruction-fetch stage: stalls the core until the word at pc is buffered.
// Define FETCH_PREFETCH_EN for a second entry and sequential (pc+4) prefetch.
module fetch_unit
  import fetch_pkg::*;
#(
  parameter int unsigned AW      = 14,
  parameter logic [31:0] BASE    = 32'h0040_0000,
  parameter int unsigned TIMEOUT = 64,
  parameter logic [31:0] NOP     = NOP_DEFAULT
) (
  input  logic          clk,
  input  logic          reset,
  input  logic [31:0]   pc,
  output logic [31:0]   instr,
  output logic          cpu_enable,
  output logic          imem_req,
  output logic [AW-1:0] imem_addr,
  input  logic [31:0]   imem_rdata,
  input  logic          imem_valid,
  output logic          fault,
  output logic [1:0]    fault_code
);

`ifdef FETCH_PREFETCH_EN
  localparam bit PfEn = 1'b1;
`else
  localparam bit PfEn = 1'b0;
`endif
  localparam int unsigned Entries = PfEn ? 2 : 1;
  localparam int unsigned CW      = $clog2(TIMEOUT + 1);

  // Range check runs on the full 32-bit index before truncation to AW bits.
  function automatic logic [1:0] addr_check(input logic [31:0] a);
    logic [31:0] idx;
    idx = (a - BASE) >> 2;
    if (a[1:0] != 2'b00) return FC_MISALIGN;
    if (a < BASE || (idx >> AW) != 32'd0) return FC_RANGE;
    return FC_NONE;
  endfunction

  function automatic logic [AW-1:0] word_idx(input logic [31:0] a);
    logic [31:0] off;
    off = (a - BASE) >> 2;
    return off[AW-1:0];
  endfunction

  fetch_state_t  state_q;
  logic          req_q, fill_idx_q, fault_q;
  logic [AW-1:0] addr_q;
  logic [31:0]   req_pc_q;
  logic [CW-1:0] cnt_q;
  logic [1:0]    code_q;

  logic        hit, hit_idx, la_hit, pf_ok, chain_ok;
  logic        issue, issue_idx, set_fault;
  logic [31:0] issue_pc, la_addr;
  logic [1:0]  set_code, pc_code;

  assign la_addr = (state_q == StWait) ? req_pc_q + 32'd4 : pc + 32'd4;
  assign pc_code = addr_check(pc);
  assign pf_ok   = PfEn && addr_check(pc + 32'd4) == FC_NONE && !la_hit;
  // Chain the next sequential prefetch on a fill only if the core is not waiting elsewhere
  // and the target entry does not hold the word the core is currently using.
  assign chain_ok = PfEn && (pc == req_pc_q || hit) && !(hit && hit_idx == ~fill_idx_q) &&
                    addr_check(req_pc_q + 32'd4) == FC_NONE && !la_hit;

  fetch_buffer #(
    .Entries (Entries),
    .Nop     (NOP)
  ) u_buffer (
    .clk_i     (clk),
    .rst_ni    (reset),
    .pc_i      (pc),
    .la_addr_i (la_addr),
    .wr_en_i   (state_q == StWait && imem_valid),
    .wr_idx_i  (fill_idx_q),
    .wr_tag_i  (req_pc_q),
    .wr_data_i (imem_rdata),
    .hit_o     (hit),
    .hit_idx_o (hit_idx),
    .la_hit_o  (la_hit),
    .instr_o   (instr)
  );

  always_comb begin
    issue     = 1'b0;
    issue_pc  = pc;
    issue_idx = 1'b0;
    set_fault = 1'b0;
    set_code  = FC_NONE;
    unique case (state_q)
      StIdle: begin
        if (!fault_q) begin
          if (!hit) begin
            if (pc_code != FC_NONE) begin
              set_fault = 1'b1;
              set_code  = pc_code;
            end else begin
              issue = 1'b1;
            end
          end else if (pf_ok) begin
            issue     = 1'b1;
            issue_pc  = pc + 32'd4;
            issue_idx = ~hit_idx;
          end
        end
      end
      StWait: begin
        if (imem_valid) begin
          if (chain_ok) begin
            issue     = 1'b1;
            issue_pc  = req_pc_q + 32'd4;
            issue_idx = ~fill_idx_q;
          end
        end else if (cnt_q == CW'(TIMEOUT)) begin
          set_fault = 1'b1;
          set_code  = FC_TIMEOUT;
        end
      end
      default: ;
    endcase
  end

  always_ff @(posedge clk or negedge reset) begin
    if (!reset) begin
      state_q    <= StIdle;
      req_q      <= 1'b0;
      addr_q     <= '0;
      req_pc_q   <= '0;
      cnt_q      <= '0;
      fill_idx_q <= 1'b0;
      fault_q    <= 1'b0;
      code_q     <= FC_NONE;
    end else begin
      req_q <= 1'b0;
      if (set_fault) begin
        fault_q <= 1'b1;
        code_q  <= set_code;
      end
      if (issue) begin
        req_q      <= 1'b1;
        addr_q     <= word_idx(issue_pc);
        req_pc_q   <= issue_pc;
        cnt_q      <= '0;
        fill_idx_q <= issue_idx;
      end
      unique case (state_q)
        StIdle: if (issue) state_q <= StWait;
        StWait: begin
          if (imem_valid)     state_q <= issue ? StWait : StIdle;
          else if (set_fault) state_q <= StFault;
          else                cnt_q   <= cnt_q + 1'b1;
        end
        StFault: ;
        default: state_q <= StIdle;
      endcase
    end
  end

  assign cpu_enable = hit && !fault_q;
  assign imem_req   = req_q;
  assign imem_addr  = addr_q;
  assign fault      = fault_q;
  assign fault_code = code_q;

endmodule

// File: doc/fetch_unit.md
Name: fetch_unit

Overview:
- Instruction-fetch stage directly upstream of the single-cycle MIPS datapath.
- Takes the datapath's `pc` and returns `instr` from a variable-latency instruction memory.
- Drives the datapath `enable` (`cpu_enable`) low to stall the core until the instruction at `pc` is held in a local buffer.
- Reports misaligned, out-of-range and memory-timeout faults.

Parameters:
- `AW`, 14: instruction-memory word-address width (16K words).
- `BASE`, 32'h0040_0000: byte address of imem word 0 (MIPS text segment).
- `TIMEOUT`, 64: max cycles from `imem_req` to `imem_valid` before fault.
- `NOP`, 32'h0000_0000: instruction driven on `instr` when not hit.

Ports:
- `clk`  in  1  system clock, rising edge.
- `reset`  in  1  asynchronous, active-low reset.
- `pc`  in  32  current PC from datapath.
- `instr`  out  32  instruction at `pc`; valid when `cpu_enable`=1, else `NOP`.
- `cpu_enable`  out  1  to datapath `enable`; 1 = instruction ready, core may advance.
- `imem_req`  out  1  one-cycle request pulse to imem.
- `imem_addr`  out  AW  word address, valid in the `imem_req` cycle.
- `imem_rdata`  in  32  read data, valid with `imem_valid`.
- `imem_valid`  in  1  one-cycle response pulse, ≥1 cycle after `imem_req`, exactly one per request.
- `fault`  out  1  sticky fault flag; cleared only by reset.
- `fault_code`  out  2  fault cause: 00 none, 01 misaligned, 10 out of range, 11 timeout.

Behaviour:
- Reset (async, `reset`=0), all forced:
  - state=IDLE, buffer valid bits=0, tags/data=0.
  - `imem_req`=0, `imem_addr`=0, `cpu_enable`=0, `instr`=`NOP`, `fault`=0, `fault_code`=00, timeout counter=0.
- Buffer entry E0: `tag0`[31:0], `data0`[31:0], `v0`.
- `hit` = `v0` && `tag0`==`pc`, purely combinational.
- `cpu_enable` = `hit` && !`fault`; `instr` = `hit` ? `data0` : `NOP`. No added latency.
- Word index = (`pc` − `BASE`) >> 2.
  - Out of range if `pc` < `BASE` or index ≥ 2^`AW`.
  - Misaligned if `pc`[1:0] != 0.
- FSM IDLE:
  - `hit` → stay.
  - Else if misaligned or out of range → set `fault`/`fault_code`, stay IDLE; no request is ever issued for that `pc`.
  - Else pulse `imem_req` with `imem_addr` = index[AW-1:0], latch `req_pc`=`pc`, clear counter → WAIT.
- FSM WAIT:
  - Counter increments each cycle.
  - `imem_valid` → `data0`<=`imem_rdata`, `tag0`<=`req_pc`, `v0`<=1 → IDLE. Hit is visible the next cycle.
  - Counter reaches `TIMEOUT` without valid → `fault`=1, `code`=11 → FAULT.
- FSM FAULT: terminal until reset. `cpu_enable`=0; late `imem_valid` ignored.
- Latency: miss to `cpu_enable`=1 is L+1 cycles after the `imem_req` cycle, for memory latency L. Each instruction costs L+2 cycles minimum.
- `pc` changes while in WAIT (not legal while `cpu_enable`=0): fill still completes with `req_pc` tag; the resulting miss triggers a new fetch.
- `imem_valid` in IDLE (spurious): ignored; no buffer update.
- At most one request outstanding, always.
- Reset mid-WAIT: a response arriving after reset release is ignored (state IDLE, spurious rule).
- Tag compares use all 32 bits; index arithmetic is 32-bit unsigned, truncated only after the range check.

Optional Feature:
- Macro `FETCH_PREFETCH_EN`.
- Defined:
  - Adds entry E1 (`tag1`/`data1`/`v1`); `hit` = match in E0 or E1, `instr` from the matching entry.
  - In IDLE with `hit`, if `pc`+4 is in range, aligned and not buffered, issue a prefetch for `pc`+4 into the entry not matching `pc` → WAIT (prefetch flavour).
  - Prefetch timeout also faults.
  - A demand miss arising while a prefetch is outstanding waits for that response, then issues normally.
  - Straight-line code with L=1 sustains one instruction per 2 cycles after the first.
- Undefined: E0 only; behaviour exactly as above.

Decomposition:
- Shared package `fetch_pkg`:
  - state enum `fetch_state_t` {IDLE, WAIT, FAULT}.
  - `fault_code` constants `FC_NONE`, `FC_MISALIGN`, `FC_RANGE`, `FC_TIMEOUT`.
  - `NOP` default.
- One natural sub-module: `fetch_buffer`, holding tag/data/valid entries, hit compare, and the `instr` mux. Parameterised on entry count (1 or 2).

Test Plan:
- Reset release, `pc`=32'h0040_0000, imem L=1 returning 32'h2008_0005 → `imem_req` with `imem_addr`=0 in cycle 1; `cpu_enable`=1, `instr`=32'h2008_0005 in cycle 3.
- Then `pc`=32'h0040_0004, L=3 → `imem_addr`=1; `cpu_enable` low for 5 cycles then high; `instr` = returned word.
- `pc`=32'h0040_0002 → `fault`=1, `fault_code`=01, no `imem_req`, `cpu_enable`=0. Same for `pc`=32'h0000_1000 → `code`=10.
- No `imem_valid` for 64 cycles → `fault_code`=11. A later `imem_valid` does not raise `cpu_enable`.
- Assert `reset`=0 mid-WAIT, release, then inject `imem_valid` → ignored, `v0`=0, new request issued for current `pc`.
- `FETCH_PREFETCH_EN`: sequential `pc` 0x00400000..0x00400010, L=1 → after the first fetch, `cpu_enable` is high every other cycle, and prefetch `imem_addr` = `pc` index + 1.
